imem_loader: RTL

//  Writer side of the instruction-memory interface. The pipeline only reads IM (PC-indexed, word-addressed).

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_e;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = LEN_BYTES * 8;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, IM write port and pipeline control bundle of the loader.
interface imem_loader_if #(
    parameter int unsigned AW = 32
);
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          imwe;
    logic [AW-1:0] imwa;
    logic [31:0]   imwd;
    logic          cpurst;
    logic          done;
    logic          err;

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, imwe, imwa, imwd, cpurst, done, err
    );

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, imwe, imwa, imwd, cpurst, done, err
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian bytes into 32-bit words; word_ready flags the byte that completes a word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word
);

    // Only the three earlier bytes need storage; the fourth arrives on byte_in.
    logic [23:0]      sreg_q;
    logic [IDX_W-1:0] idx_q;

    assign word_ready = shift_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign word       = {sreg_q, byte_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else if (clr) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else if (shift_en) begin
            sreg_q <= {sreg_q[15:0], byte_in};
            idx_q  <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into IM and holds the pipeline in reset until it is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic               byte_ready_q, byte_ready_d;
    logic               imwe_q, imwe_d;
    logic [AW-1:0]      imwa_q, imwa_d;
    logic [31:0]        imwd_q, imwd_d;
    logic               cpurst_q, cpurst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               pk_clr;
    logic               pk_shift;
    logic               word_ready;
    logic [31:0]        word;
    logic [LEN_W-1:0]   hdr_len;

    assign xfer     = bus.byte_valid && byte_ready_q;
    assign pk_shift = xfer && (state_q == StData);
    assign hdr_len  = {len_q[LEN_W-1:8], bus.byte_in};

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr),
        .shift_en   (pk_shift),
        .byte_in    (bus.byte_in),
        .word_ready (word_ready),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        wcnt_d       = wcnt_q;
        byte_ready_d = byte_ready_q;
        imwe_d       = 1'b0;
        imwa_d       = imwa_q;
        imwd_d       = imwd_q;
        cpurst_d     = cpurst_q;
        done_d       = done_q;
        err_d        = err_q;
        pk_clr       = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.start) begin
                    state_d      = StLenHi;
                    byte_ready_d = 1'b1;
                    cpurst_d     = 1'b1;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    pk_clr       = 1'b1;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[LEN_W-1:8] = bus.byte_in;
                    state_d          = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d = hdr_len;
                    if (hdr_len == '0) begin
                        state_d      = StDone;
                        byte_ready_d = 1'b0;
                        cpurst_d     = 1'b0;
                        done_d       = 1'b1;
                    end else if (32'(hdr_len) > DEPTH) begin
                        state_d      = StErr;
                        byte_ready_d = 1'b0;
                        err_d        = 1'b1;
                    end else begin
                        state_d = StData;
                        wcnt_d  = '0;
                        pk_clr  = 1'b1;
                    end
                end
            end
            StData: begin
                if (word_ready) begin
                    imwe_d = 1'b1;
                    imwa_d = AW'(wcnt_q);
                    imwd_d = word;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q + 1'b1 == len_q) begin
                        byte_ready_d = 1'b0;
                    end
                end
                // Leave DATA on the edge that commits the final write, so IM holds
                // every word by the time the pipeline leaves reset.
                if (imwe_q && (wcnt_q == len_q)) begin
                    state_d  = StDone;
                    cpurst_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d      = StIdle;
                byte_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            wcnt_q       <= '0;
            byte_ready_q <= 1'b0;
            imwe_q       <= 1'b0;
            imwa_q       <= '0;
            imwd_q       <= '0;
            cpurst_q     <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            byte_ready_q <= byte_ready_d;
            imwe_q       <= imwe_d;
            imwa_q       <= imwa_d;
            imwd_q       <= imwd_d;
            cpurst_q     <= cpurst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imwe       = imwe_q;
    assign bus.imwa       = imwa_q;
    assign bus.imwd       = imwd_q;
    assign bus.cpurst     = cpurst_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
